// File: rtl/obj_spawn_if.sv
// Spawn handshake between the object spawn scheduler and the game logic slot writer.
// The scheduler is the master: it offers a slot index and object word until the writer accepts.
interface obj_spawn_if;
  logic        spawn_valid;
  logic [2:0]  spawn_slot;
  logic [25:0] spawn_obj;
  logic        spawn_ready;

  modport master (output spawn_valid, output spawn_slot, output spawn_obj, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_slot, input spawn_obj, output spawn_ready);
endinterface

// File: rtl/obj_spawn_scheduler.sv
// Schedules new collectable objects from a frame timer (R0) and MIDI notes (R1) into the
// lowest free object slot, arbitrating round-robin and counting requests lost to full slots.
module obj_spawn_scheduler #(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SPAWN_MIN_GAP = 16,
  parameter int V_MIN         = 32,
  parameter int V_MAX         = 736
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vsync_pulse,
  input  logic              enable,
  input  logic [4:0]        slot_busy,
  input  logic [31:0]       random,
  input  logic              midi_req,
  input  logic [6:0]        midi_key,
  output logic              midi_ack,
  obj_spawn_if.master       spawn,
  output logic [7:0]        dropped
);

  localparam logic [10:0] HPOS_C   = 11'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  VMIN_C   = 10'(V_MIN);
  localparam logic [9:0]  VMAX_C   = 10'(V_MAX);
  localparam logic [4:0]  GAP_MIN_C = 5'(SPAWN_MIN_GAP);

  typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, ISSUE = 2'd2} state_t;

  function automatic logic [9:0] force_nonzero(input logic [9:0] v);
    return (v == 10'd0) ? 10'd1 : v;
  endfunction

  function automatic logic [9:0] timer_vpos(input logic [9:0] r);
    logic [9:0] v;
    if (r < VMIN_C) v = VMIN_C;
    else if (r > VMAX_C) v = VMAX_C;
    else v = r;
    return force_nonzero(v);
  endfunction

  function automatic logic [9:0] midi_vpos(input logic [6:0] key);
    logic [6:0] kc;
    logic [4:0] k;
    if (key < 7'd48) kc = 7'd48;
    else if (key > 7'd79) kc = 7'd79;
    else kc = key;
    k = 5'(kc - 7'd48);
    return force_nonzero(VMAX_C - {1'b0, k, 4'b0000});
  endfunction

  function automatic logic [2:0] lowest_free(input logic [4:0] f);
    if (f[0]) return 3'd0;
    else if (f[1]) return 3'd1;
    else if (f[2]) return 3'd2;
    else if (f[3]) return 3'd3;
    else return 3'd4;
  endfunction

  state_t      state_r, state_nxt_s;
  logic        grant_r, grant_nxt_s;   // 0: timer owns the transaction, 1: MIDI
  logic        rr_r, rr_nxt_s;         // 0: R0 favoured on a tie
  logic        spawn_valid_r, valid_nxt_s;
  logic [2:0]  spawn_slot_r, slot_nxt_s;
  logic [25:0] spawn_obj_r, obj_nxt_s;
  logic        midi_ack_r, ack_nxt_s;
  logic [7:0]  dropped_r;
  logic [4:0]  gap_cnt_r, gap_target_r;
  logic        timer_pend_r;
  logic        expire_s, timer_drop_s, clr_timer_s, fsm_drop_s;
  logic        timer_req_s, midi_req_s;
  logic [4:0]  free_s;
  logic [1:0]  drop_inc_s;
  logic [8:0]  drop_sum_s;
  logic        unused_random_s;

  assign unused_random_s = ^random[31:10];
  assign expire_s     = enable && (gap_cnt_r == gap_target_r);
  // A second expiry while the first is still queued is lost, unless it is consumed this cycle.
  assign timer_drop_s = expire_s && timer_pend_r && !clr_timer_s;
  assign timer_req_s  = timer_pend_r && enable;
  assign midi_req_s   = midi_req && !midi_ack_r;
  assign free_s       = ~slot_busy;
  assign drop_inc_s   = {1'b0, fsm_drop_s} + {1'b0, timer_drop_s};
  assign drop_sum_s   = {1'b0, dropped_r} + {7'd0, drop_inc_s};

  // Frame timer: counts vsync ticks and raises a pending R0 request at each randomised gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt_r    <= 5'd0;
      gap_target_r <= GAP_MIN_C;
      timer_pend_r <= 1'b0;
    end else if (!enable) begin
      gap_cnt_r    <= 5'd0;
      timer_pend_r <= 1'b0;
    end else if (expire_s) begin
      gap_cnt_r    <= vsync_pulse ? 5'd1 : 5'd0;
      gap_target_r <= GAP_MIN_C + {1'b0, random[3:0]};
      timer_pend_r <= 1'b1;
    end else begin
      if (vsync_pulse) gap_cnt_r <= gap_cnt_r + 5'd1;
      if (clr_timer_s) timer_pend_r <= 1'b0;
    end
  end

  // State register plus registered handshake outputs and saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_r       <= 1'b0;
      rr_r          <= 1'b0;
      spawn_valid_r <= 1'b0;
      spawn_slot_r  <= 3'd0;
      spawn_obj_r   <= 26'd0;
      midi_ack_r    <= 1'b0;
      dropped_r     <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      grant_r       <= grant_nxt_s;
      rr_r          <= rr_nxt_s;
      spawn_valid_r <= valid_nxt_s;
      spawn_slot_r  <= slot_nxt_s;
      spawn_obj_r   <= obj_nxt_s;
      midi_ack_r    <= ack_nxt_s;
      dropped_r     <= (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
    end
  end

  // Arbitration, slot selection and handshake sequencing.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    rr_nxt_s    = rr_r;
    valid_nxt_s = spawn_valid_r;
    slot_nxt_s  = spawn_slot_r;
    obj_nxt_s   = spawn_obj_r;
    ack_nxt_s   = 1'b0;
    clr_timer_s = 1'b0;
    fsm_drop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!enable && midi_req_s) begin
          ack_nxt_s = 1'b1;
        end else if (timer_req_s && (!midi_req_s || !rr_r)) begin
          grant_nxt_s = 1'b0;
          rr_nxt_s    = 1'b1;
          state_nxt_s = SELECT;
        end else if (midi_req_s) begin
          grant_nxt_s = 1'b1;
          rr_nxt_s    = 1'b0;
          state_nxt_s = SELECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SELECT: begin
        if (free_s == 5'd0) begin
          fsm_drop_s = 1'b1;
          if (grant_r) ack_nxt_s = 1'b1;
          else clr_timer_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          slot_nxt_s  = lowest_free(free_s);
          if (grant_r) obj_nxt_s = {3'b000, 2'b01, HPOS_C, midi_vpos(midi_key)};
          else obj_nxt_s = {3'b000, 2'b00, HPOS_C, timer_vpos(random[9:0])};
          valid_nxt_s = 1'b1;
          state_nxt_s = ISSUE;
        end
      end
      ISSUE: begin
        if (spawn.spawn_ready) begin
          valid_nxt_s = 1'b0;
          if (grant_r) ack_nxt_s = 1'b1;
          else clr_timer_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign spawn.spawn_valid = spawn_valid_r;
  assign spawn.spawn_slot  = spawn_slot_r;
  assign spawn.spawn_obj   = spawn_obj_r;
  assign midi_ack          = midi_ack_r;
  assign dropped           = dropped_r;

endmodule

// File: tb/tb_obj_spawn_scheduler.sv
// Self-checking bench for obj_spawn_scheduler: expected spawns are queued when stimulus is
// driven and compared when the scheduler offers them on the spawn handshake.
module tb_obj_spawn_scheduler;
  logic        clock = 1'b0;
  logic        reset;
  logic        vsync_pulse;
  logic        enable;
  logic [4:0]  slot_busy;
  logic [31:0] random;
  logic        midi_req;
  logic [6:0]  midi_key;
  logic        midi_ack;
  logic [7:0]  dropped;

  obj_spawn_if sif();

  obj_spawn_scheduler dut (
    .clock(clock), .reset(reset), .vsync_pulse(vsync_pulse), .enable(enable),
    .slot_busy(slot_busy), .random(random), .midi_req(midi_req), .midi_key(midi_key),
    .midi_ack(midi_ack), .spawn(sif), .dropped(dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  slot;
    logic [25:0] obj;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int valid_cycles = 0;

  // Event counters sampled mid-cycle.
  always @(negedge clock) begin
    if (midi_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    if (sif.spawn_valid === 1'b1) valid_cycles <= valid_cycles + 1;
  end

  function automatic logic [25:0] mk_obj(input logic [1:0] id, input logic [9:0] v);
    return {3'b000, id, 11'd1023, v};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync_pulse = 1'b0; enable = 1'b0; slot_busy = 5'd0; random = 32'd0;
    midi_req = 1'b0; midi_key = 7'd0; sif.spawn_ready = 1'b0;
    q.delete();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_vsync(input int count);
    for (int i = 0; i < count; i++) begin
      vsync_pulse = 1'b1; tick(); vsync_pulse = 1'b0;
      if (i < count - 1) tick();
    end
  endtask

  task automatic wait_spawn(input string name, input bit is_midi);
    exp_t e;
    int n = 0;
    while (sif.spawn_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (sif.spawn_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid timeout got=%b want=1", name, sif.spawn_valid);
    end else if (q.size() == 0) begin
      errors++; $display("FAIL %s_unexpected spawn slot=%0d", name, sif.spawn_slot);
    end else begin
      e = q.pop_front();
      checks++;
      if (sif.spawn_slot !== e.slot) begin
        errors++; $display("FAIL %s_slot got=%0d want=%0d", name, sif.spawn_slot, e.slot);
      end
      checks++;
      if (sif.spawn_obj !== e.obj) begin
        errors++; $display("FAIL %s_obj got=%h want=%h", name, sif.spawn_obj, e.obj);
      end
      sif.spawn_ready = 1'b1; tick(); sif.spawn_ready = 1'b0;
      checks++;
      if (sif.spawn_valid !== 1'b0) begin
        errors++; $display("FAIL %s_valid_after_ready got=%b want=0", name, sif.spawn_valid);
      end
      checks++;
      if (midi_ack !== logic'(is_midi)) begin
        errors++; $display("FAIL %s_ack got=%b want=%b", name, midi_ack, is_midi);
      end
      if (is_midi) midi_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sif.spawn_valid !== 1'b0 || sif.spawn_slot !== 3'd0 || sif.spawn_obj !== 26'd0) begin
      errors++; $display("FAIL reset_spawn got=%b/%0d/%h want=0/0/0", sif.spawn_valid, sif.spawn_slot, sif.spawn_obj);
    end
    checks++;
    if (midi_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", midi_ack); end
    checks++;
    if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped got=%0d want=0", dropped); end
  endtask

  task automatic test_timer();
    int n = 0;
    do_reset();
    enable = 1'b1;
    q.push_back('{3'd0, mk_obj(2'b00, 10'd32)});
    pulse_vsync(16);
    while (sif.spawn_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL timer_latency got=%0d want=3", n); end
    wait_spawn("timer", 1'b0);
  endtask

  task automatic test_midi();
    int ack_base;
    do_reset();
    enable = 1'b1; slot_busy = 5'b00111;
    ack_base = ack_cnt;
    q.push_back('{3'd3, mk_obj(2'b01, 10'd544)});
    midi_key = 7'd60; midi_req = 1'b1;
    tick();
    checks++;
    if (sif.spawn_valid !== 1'b0) begin errors++; $display("FAIL midi_early_valid got=%b want=0", sif.spawn_valid); end
    tick();
    checks++;
    if (sif.spawn_valid !== 1'b1) begin errors++; $display("FAIL midi_latency got=%b want=1", sif.spawn_valid); end
    wait_spawn("midi", 1'b1);
    tick(); tick();
    checks++;
    if (ack_cnt - ack_base != 1) begin errors++; $display("FAIL midi_ack_count got=%0d want=1", ack_cnt - ack_base); end
  endtask

  task automatic test_round_robin();
    do_reset();
    enable = 1'b1; random = 32'h0000_03FF;
    q.push_back('{3'd0, mk_obj(2'b00, 10'd736)});
    q.push_back('{3'd1, mk_obj(2'b01, 10'd736)});
    pulse_vsync(16);
    tick();
    midi_key = 7'd30; midi_req = 1'b1;
    wait_spawn("rr_r0", 1'b0);
    slot_busy = 5'b00001;
    wait_spawn("rr_r1", 1'b1);
  endtask

  task automatic test_saturation();
    int ack_base, vc_base, n;
    do_reset();
    enable = 1'b1; slot_busy = 5'b11111; midi_key = 7'd60;
    ack_base = ack_cnt; vc_base = valid_cycles;
    for (int i = 0; i < 300; i++) begin
      midi_req = 1'b1; n = 0;
      while (midi_ack !== 1'b1 && n < 10) begin tick(); n++; end
      midi_req = 1'b0;
      if (midi_ack !== 1'b1) begin
        checks++; errors++; $display("FAIL sat_ack_timeout req=%0d got=0 want=1", i);
        break;
      end
      tick();
      if (i == 99) begin
        checks++;
        if (dropped !== 8'd100) begin errors++; $display("FAIL sat_dropped_100 got=%0d want=100", dropped); end
      end
    end
    tick();
    checks++;
    if (ack_cnt - ack_base != 300) begin errors++; $display("FAIL sat_acks got=%0d want=300", ack_cnt - ack_base); end
    checks++;
    if (valid_cycles != vc_base) begin errors++; $display("FAIL sat_no_spawn got=%0d want=0", valid_cycles - vc_base); end
    checks++;
    if (dropped !== 8'd255) begin errors++; $display("FAIL sat_dropped got=%0d want=255", dropped); end
  endtask

  task automatic test_hold();
    int n = 0, bad = 0, vc_base;
    do_reset();
    enable = 1'b1; slot_busy = 5'b10101;
    q.push_back('{3'd1, mk_obj(2'b01, 10'd240)});
    midi_key = 7'd90; midi_req = 1'b1;
    while (sif.spawn_valid !== 1'b1 && n < 10) begin tick(); n++; end
    for (int i = 0; i < 50; i++) begin
      if (sif.spawn_valid !== 1'b1 || sif.spawn_slot !== q[0].slot || sif.spawn_obj !== q[0].obj) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
    wait_spawn("hold", 1'b1);
    vc_base = valid_cycles;
    tick(); tick(); tick();
    checks++;
    if (valid_cycles != vc_base) begin errors++; $display("FAIL hold_single_write got=%0d want=0", valid_cycles - vc_base); end
  endtask

  task automatic test_reset_issue();
    int n = 0, ack_base, vc_base;
    do_reset();
    enable = 1'b1;
    midi_key = 7'd60; midi_req = 1'b1;
    while (sif.spawn_valid !== 1'b1 && n < 10) begin tick(); n++; end
    ack_base = ack_cnt;
    reset = 1'b1; midi_req = 1'b0;
    tick();
    checks++;
    if (sif.spawn_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid got=%b want=0", sif.spawn_valid); end
    reset = 1'b0; q.delete();
    tick(); tick(); tick();
    checks++;
    if (ack_cnt != ack_base) begin errors++; $display("FAIL rst_issue_ack got=%0d want=0", ack_cnt - ack_base); end
    checks++;
    if (dropped !== 8'd0) begin errors++; $display("FAIL rst_issue_dropped got=%0d want=0", dropped); end
    enable = 1'b0; vc_base = valid_cycles; n = 0;
    midi_req = 1'b1;
    while (midi_ack !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (midi_ack !== 1'b1) begin errors++; $display("FAIL disabled_ack got=%b want=1", midi_ack); end
    midi_req = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (valid_cycles != vc_base) begin errors++; $display("FAIL disabled_no_spawn got=%0d want=0", valid_cycles - vc_base); end
    checks++;
    if (dropped !== 8'd0) begin errors++; $display("FAIL disabled_dropped got=%0d want=0", dropped); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_midi();
    test_round_robin();
    test_saturation();
    test_hold();
    test_reset_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
